// File: rtl/spi_cmd_master_module.sv
// spi_cmd_master_module: SPI mode-0 master framing a command byte and a data byte, returning the slave's reply byte.
// Optional ID-reply check on command 0x06 is built when SPI_CMD_ID_CHECK_EN is defined.
module spi_cmd_master_module #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int BYTE_GAP = 8,
  parameter int CS_HOLD  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iStart,
  input  logic [7:0] iCmd,
  input  logic [7:0] iData,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oRxData,
  output logic       oErr,
  output logic       spi_ncs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  localparam int MAXD = (CS_SETUP > BYTE_GAP) ? ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD)
                                              : ((BYTE_GAP > CS_HOLD) ? BYTE_GAP : CS_HOLD);
  localparam int CW = $clog2(MAXD + 1);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SHIFT0 = 3'd2, GAP = 3'd3,
                         SHIFT1 = 3'd4, HOLD = 3'd5, DONE = 3'd6;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ph_q, ph_d;
  logic          hi_q, hi_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    cmd_q, cmd_d, data_q, data_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic [1:0]    sync_q, sync_d;
  logic          ncs_q, ncs_d, sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic          fin;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    hi_d    = hi_q;
    bit_d   = bit_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    rx_sh_d = rx_sh_q;
    sync_d  = {sync_q[0], spi_miso};
    case (state_q)
      IDLE, DONE: begin
        state_d = iStart ? SETUP : IDLE;
        if (iStart) begin
          cnt_d  = CW'(CS_SETUP - 1);
          cmd_d  = iCmd;
          data_d = iData;
        end
      end
      SETUP, GAP: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = (state_q == SETUP) ? SHIFT0 : SHIFT1;
          ph_d    = 8'(CLK_DIV - 1);
          hi_d    = 1'b0;
          bit_d   = 3'd0;
        end
      end
      SHIFT0, SHIFT1: begin
        ph_d = ph_q - 8'd1;
        if (ph_q == 8'd0) begin
          ph_d = 8'(CLK_DIV - 1);
          hi_d = !hi_q;
          // End of the high phase closes the bit: sample MISO and advance.
          if (hi_q) begin
            bit_d   = bit_q + 3'd1;
            rx_sh_d = (state_q == SHIFT1) ? {rx_sh_q[6:0], sync_q[1]} : rx_sh_q;
            if (bit_q == 3'd7) begin
              state_d = (state_q == SHIFT0) ? GAP : HOLD;
              cnt_d   = (state_q == SHIFT0) ? CW'(BYTE_GAP - 1) : CW'(CS_HOLD - 1);
            end
          end
        end
      end
      HOLD: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? DONE : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from next-state values so pins are glitch-free yet aligned with state.
  always_comb begin
    fin    = (state_q == HOLD) && (state_d == DONE);
    rx_d   = fin ? rx_sh_q : rx_q;
    ncs_d  = !(state_d inside {SETUP, SHIFT0, GAP, SHIFT1});
    busy_d = state_d inside {SETUP, SHIFT0, GAP, SHIFT1, HOLD};
    sclk_d = (state_d == SHIFT0 || state_d == SHIFT1) && hi_d;
    mosi_d = (state_d == SHIFT0) ? cmd_d[~bit_d] :
             (state_d == GAP)    ? cmd_d[0] :
             (state_d == SHIFT1) ? data_d[~bit_d] : 1'b0;
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      sync_q  <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      sync_q  <= sync_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
`ifdef SPI_CMD_ID_CHECK_EN
  logic err_q, err_d;
  always_comb err_d = fin ? (cmd_q == 8'h06 && rx_sh_q != 8'hD4) : err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign oErr = err_q;
`else
  assign oErr = 1'b0;
`endif
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oRxData  = rx_q;
  assign spi_ncs  = ncs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
endmodule

// File: doc/spi_cmd_master_module.md
# spi_cmd_master_module

Transmitting end of the spider-robot SPI command link. Frames a two-byte command (command byte, then data byte) onto a 4-wire SPI bus as bus master, and returns the byte the slave shifts back during the data byte. It lets one FPGA drive the LED/servo command set of a remote SPI-slave controller. The command set is 0x06 ID query, 0xA1 LED, and 0xA3–0xAE servo channels.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 2..255.
- CS_SETUP, 2: clk cycles from NCS fall to the first SCLK activity; minimum 1.
- BYTE_GAP, 8: clk cycles between byte 0 and byte 1, with NCS low and SCLK low; minimum 1. It gives the slave time to load its reply.
- CS_HOLD, 4: clk cycles NCS is held high after a frame before done; minimum 1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- iStart, input, 1: frame request; sampled only while oBusy=0.
- iCmd, input, 8: command byte.
- iData, input, 8: data byte.
- oBusy, output, 1: frame in progress.
- oDone, output, 1: one-cycle pulse at frame completion.
- oRxData, output, 8: MISO byte captured during byte 1; valid from oDone and held until the next oDone.
- oErr, output, 1: ID-check failure; see Configuration.
- spi_ncs, output, 1: chip select, active low.
- spi_sclk, output, 1: serial clock.
- spi_mosi, output, 1: master out.
- spi_miso, input, 1: master in; asynchronous.

## Operation
- SPI mode 0: CPOL=0, CPHA=0, MSB first.
- Reset values: spi_ncs=1, spi_sclk=0, spi_mosi=0, oBusy=0, oDone=0, oRxData=0, oErr=0.
- States: IDLE → SETUP → SHIFT0 → GAP → SHIFT1 → HOLD → DONE → IDLE.
- IDLE:
  - If iStart=1, latch iCmd and iData.
  - Next cycle, assert spi_ncs=0 and oBusy=1, and enter SETUP.
- SETUP: stay CS_SETUP cycles.
- SHIFT0 / SHIFT1: 8 bits each, and each bit takes 2·CLK_DIV cycles.
  - Low phase: spi_sclk=0 for CLK_DIV cycles; spi_mosi carries the current bit for the whole bit time.
  - High phase: spi_sclk=1 for CLK_DIV cycles.
  - MISO capture: spi_miso passes a 2-FF synchronizer, and the synchronized value is shifted in on the last clk cycle of each high phase.
  - SHIFT0 sends the command byte, SHIFT1 sends the data byte.
- MISO handling: bits shifted in during SHIFT0 are discarded. Bits from SHIFT1 form oRxData.
- GAP: BYTE_GAP cycles, spi_sclk=0, spi_mosi holds the last bit.
- HOLD: spi_ncs=1, spi_sclk=0, spi_mosi=0, for CS_HOLD cycles.
- DONE, one cycle:
  - oDone=1 and oBusy=0.
  - oRxData and oErr update.
  - An iStart in this cycle is accepted, exactly as from IDLE.
- iStart while oBusy=1 is ignored; it is not queued.
- iCmd/iData changes after acceptance have no effect on the current frame.
- Any command value is transmitted; there is no command filtering.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous), so spi_ncs rises at once. The slave treats this as an aborted frame.
- Counters: bit counter 3 bits; phase counter 8 bits; one shared delay counter sized for max(CS_SETUP, BYTE_GAP, CS_HOLD).

## Timing
- Define T0 as the cycle where iStart is accepted.
- spi_ncs falls at T0+1.
- First SCLK rise at T0+1+CS_SETUP+CLK_DIV.
- oDone at T0+1+CS_SETUP+32·CLK_DIV+BYTE_GAP+CS_HOLD. With default parameters this is T0+143.
- Back-to-back frames: the minimum NCS-high time is CS_HOLD+1 cycles. This exceeds the slave's 3-flop NCS synchronizer.

## Configuration
- Macro: SPI_CMD_ID_CHECK_EN.
- Defined:
  - In DONE, if the latched command is 0x06, oErr is set to (oRxData != 0xD4).
  - For any other command, oErr=0.
  - oErr holds until the next DONE.
- Undefined: oErr is tied to 0 and the compare logic is absent.

## Test plan
All scenarios use default parameters.
- Reset, then idle 20 cycles → spi_ncs=1, spi_sclk=0, oBusy=0, no oDone.
- iStart with iCmd=0xA1, iData=0x05, slave model → slave sees MOSI bytes 0xA1, 0x05; exactly 16 SCLK rises; oDone at T0+143; oBusy high T0+1..T0+142.
- iCmd=0x06, slave returns 0xD4 in byte 1 → oRxData=0xD4, oErr=0. Repeat with 0xD5 → oErr=1 with the macro defined, 0 without.
- Pulse iStart again at T0+50 and change iCmd → ignored; frame bytes unchanged; single oDone.
- iStart held high continuously → second frame's T0 equals the first frame's oDone cycle; spi_ncs high exactly 5 cycles between frames.
- Assert rst_n low mid-SHIFT1 → spi_ncs=1, spi_sclk=0 in the same cycle; no oDone. A frame after release completes normally.
